// File: rtl/signed_mult_controller.sv
// Sequencing controller for a shift-add unsigned multiplier datapath: takes signed operands,
// feeds magnitudes to the datapath, and sign-corrects the unsigned product on the way out.
module signed_mult_controller #(
   parameter int WIDTH   = 8,
   parameter int PWIDTH  = 14,
   parameter int RWIDTH  = 16,
   parameter int MAX_RUN = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WIDTH-1:0]  multiplier,
   input  logic [WIDTH-1:0]  multiplicand,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [RWIDTH-1:0] result,
   output logic [WIDTH-1:0]  dp_multiplier,
   output logic [WIDTH-1:0]  dp_multiplicand,
   output logic              dp_load,
   output logic              dp_shift_en,
   output logic              dp_reg_en,
   output logic              dp_psel,
   input  logic              dp_zflag,
   input  logic              dp_lsb,
   input  logic [PWIDTH-1:0] dp_product
);

   localparam int CW = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_RUN - 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_SIGN = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic              err_q, err_d;
   logic [RWIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;

   logic [WIDTH-1:0]  a_mag, b_mag;
   logic              a_min, b_min;
   logic [RWIDTH-1:0] prod_ext, prod_signed;

   // dp_lsb is a monitor tap only; the sequencing relies solely on dp_zflag.
   logic unused_dp_lsb;
   assign unused_dp_lsb = dp_lsb;

   assign a_min = (multiplier == MIN_VAL);
   assign b_min = (multiplicand == MIN_VAL);
   assign a_mag = multiplier[WIDTH-1]   ? (~multiplier + WIDTH'(1))   : multiplier;
   assign b_mag = multiplicand[WIDTH-1] ? (~multiplicand + WIDTH'(1)) : multiplicand;

   // Zero is never negated so a negative-sign zero product still reads as 0.
   assign prod_ext    = RWIDTH'(dp_product);
   assign prod_signed = (neg_q && (dp_product != '0)) ? (~prod_ext + RWIDTH'(1)) : prod_ext;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      err_d    = err_q;
      result_d = result_q;
      mplier_d = mplier_q;
      mcand_d  = mcand_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               neg_d    = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
               result_d = '0;
               if (a_min || b_min) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d    = 1'b0;
                  mplier_d = a_mag;
                  mcand_d  = b_mag;
                  state_d  = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (dp_zflag) begin
               state_d = S_SIGN;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_SIGN: begin
            result_d = prod_signed;
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         mplier_q <= '0;
         mcand_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
         result_q <= result_d;
         mplier_q <= mplier_d;
         mcand_q  <= mcand_d;
      end
   end

   assign busy            = (state_q != S_IDLE);
   assign done            = (state_q == S_DONE);
   assign err             = err_q;
   assign result          = result_q;
   assign dp_multiplier   = mplier_q;
   assign dp_multiplicand = mcand_q;
   assign dp_load         = (state_q == S_LOAD);
   assign dp_shift_en     = (state_q == S_RUN);
   assign dp_reg_en       = (state_q == S_RUN);
   assign dp_psel         = (state_q == S_RUN);

endmodule

// File: tb/tb_signed_mult_controller.sv
// Bench for signed_mult_controller: behavioural shift-add datapath plus a result scoreboard.
module tb_signed_mult_controller;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [7:0]  multiplier, multiplicand;
   logic        busy, done, err;
   logic [15:0] result;
   logic [7:0]  dp_multiplier, dp_multiplicand;
   logic        dp_load, dp_shift_en, dp_reg_en, dp_psel;
   logic        dp_zflag, dp_lsb;
   logic [13:0] dp_product;

   typedef struct {
      logic [15:0] res;
      logic        err;
      bit          chk_res;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   load_seen;
   bit   stuck_z = 1'b0;

   always #5 clk = ~clk;

   signed_mult_controller dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .multiplier(multiplier), .multiplicand(multiplicand),
      .busy(busy), .done(done), .err(err), .result(result),
      .dp_multiplier(dp_multiplier), .dp_multiplicand(dp_multiplicand),
      .dp_load(dp_load), .dp_shift_en(dp_shift_en), .dp_reg_en(dp_reg_en), .dp_psel(dp_psel),
      .dp_zflag(dp_zflag), .dp_lsb(dp_lsb), .dp_product(dp_product)
   );

   // Shift-add datapath: multiplier shifts left, multiplicand shifts right, add on its lsb.
   logic [13:0] m_r, prod_r;
   logic [7:0]  c_r;
   always @(posedge clk) begin
      if (!rst_n) begin
         m_r <= '0; c_r <= '0; prod_r <= '0;
      end else if (dp_load) begin
         m_r <= 14'(dp_multiplier); c_r <= dp_multiplicand; prod_r <= '0;
      end else begin
         if (dp_reg_en) prod_r <= dp_psel ? prod_r + (c_r[0] ? m_r : 14'd0) : 14'd0;
         if (dp_shift_en) begin m_r <= m_r << 1; c_r <= c_r >> 1; end
      end
   end
   assign dp_zflag   = (c_r == 8'd0) && !stuck_z;
   assign dp_lsb     = c_r[0];
   assign dp_product = prod_r;

   // Scoreboard side: every done pulse pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (dp_load) load_seen = 1'b1;
      if (rst_n && done) begin
         checks++;
         assert (sb_q.size() > 0) else begin
            errors++; $error("FAIL done_unexpected: done=1 with empty scoreboard");
         end
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (err === e.err) else begin
               errors++; $error("FAIL sb_err: got %0b exp %0b", err, e.err);
            end
            if (e.chk_res) begin
               checks++;
               assert (result === e.res) else begin
                  errors++; $error("FAIL sb_result: got %h exp %h", result, e.res);
               end
            end
         end
      end
   end

   function automatic int bitlen(input int m);
      int n = 0;
      while (m > 0) begin n++; m = m >> 1; end
      return n;
   endfunction

   function automatic int mag8(input logic [7:0] v);
      return (v[7]) ? -int'($signed(v)) : int'(v);
   endfunction

   // exp_lat >= 0: exact edges from accept to done; < 0: at most -exp_lat edges.
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] er,
                         input logic ee, input bit chk_res, input int exp_lat,
                         input int glitch_at, input string tag);
      exp_t e;
      int   lat;
      bit   got;
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
      multiplier = ia; multiplicand = ib; start = 1'b1; load_seen = 1'b0;
      e.res = er; e.err = ee; e.chk_res = chk_res;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      multiplier = 8'h80; multiplicand = 8'h80;
      lat = 0; got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin got = 1'b1; break; end
         if (lat == glitch_at)     start = 1'b1;
         if (lat == glitch_at + 1) start = 1'b0;
         lat++;
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      assert (got) else begin errors++; $error("FAIL %s_timeout: no done within 40 cycles", tag); end
      if (got) begin
         checks++;
         if (exp_lat >= 0) begin
            assert (lat == exp_lat) else begin
               errors++; $error("FAIL %s_latency: got %0d exp %0d", tag, lat, exp_lat);
            end
         end else begin
            assert (lat <= -exp_lat) else begin
               errors++; $error("FAIL %s_latency: got %0d exp <= %0d", tag, lat, -exp_lat);
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int nd;
      rst_n = 1'b0; start = 1'b0; multiplier = '0; multiplicand = '0;
      repeat (3) @(negedge clk);
      checks++;
      assert ({busy, done, err, dp_load, dp_shift_en, dp_reg_en, dp_psel} === 7'b0) else begin
         errors++; $error("FAIL reset_ctrl: got %b exp 0", {busy, done, err, dp_load, dp_shift_en, dp_reg_en, dp_psel});
      end
      checks++;
      assert ({result, dp_multiplier, dp_multiplicand} === 32'h0) else begin
         errors++; $error("FAIL reset_data: got %h exp 0", {result, dp_multiplier, dp_multiplicand});
      end
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'd5, 8'd3, 16'h000F, 1'b0, 1'b1, 5, -10, "t1");
      run_op(8'hF9, 8'd6, 16'hFFD6, 1'b0, 1'b1, 6, -10, "t2a");
      checks++;
      assert (dp_multiplicand === 8'd6) else begin
         errors++; $error("FAIL t2a_dpmcand: got %0d exp 6", dp_multiplicand);
      end
      run_op(8'd7, 8'hFA, 16'hFFD6, 1'b0, 1'b1, 6, -10, "t2b");
      checks++;
      assert (dp_multiplicand === 8'd6) else begin
         errors++; $error("FAIL t2b_dpmcand: got %0d exp 6", dp_multiplicand);
      end
      run_op(8'h9C, 8'd0, 16'h0000, 1'b0, 1'b1, 3, -10, "t3a");
      run_op(8'd0, 8'hFB, 16'h0000, 1'b0, 1'b1, 6, -10, "t3b");
      run_op(8'd127, 8'h81, 16'hC0FF, 1'b0, 1'b1, 10, -10, "t4a");
      run_op(8'h81, 8'h81, 16'h3F01, 1'b0, 1'b1, 10, -10, "t4b");

      run_op(8'h80, 8'd3, 16'h0000, 1'b1, 1'b1, -2, -10, "t5a");
      checks++;
      assert (load_seen === 1'b0) else begin errors++; $error("FAIL t5a_load: got 1 exp 0"); end
      run_op(8'd3, 8'h80, 16'h0000, 1'b1, 1'b1, -2, -10, "t5b");
      checks++;
      assert (load_seen === 1'b0) else begin errors++; $error("FAIL t5b_load: got 1 exp 0"); end

      // start pulses while busy (with -128 operands) must not disturb the running op
      run_op(8'd3, 8'd100, 16'h012C, 1'b0, 1'b1, 10, 2, "busy_ign");
      repeat (6) @(negedge clk);

      // datapath never reports zero: the run limit must end the op with err
      stuck_z = 1'b1;
      run_op(8'd5, 8'd3, 16'h0000, 1'b1, 1'b0, 9, -10, "run_tmo");
      stuck_z = 1'b0;

      for (int r = 0; r < 5; r++) begin
         int va, vb, p;
         va = int'($urandom_range(0, 254)) - 127;
         vb = int'($urandom_range(0, 254)) - 127;
         p  = va * vb;
         run_op(8'(va), 8'(vb), 16'(p), 1'b0, 1'b1, bitlen(vb < 0 ? -vb : vb) + 3, -10, "rand");
      end

      // back-to-back with start held high; operands change right after acceptance
      multiplier = 8'd3; multiplicand = 8'd4; start = 1'b1;
      sb_q.push_back('{res: 16'd12, err: 1'b0, chk_res: 1'b1});
      @(negedge clk);
      multiplier = 8'hFB; multiplicand = 8'd7;
      sb_q.push_back('{res: 16'hFFDD, err: 1'b0, chk_res: 1'b1});
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (nd == 2) begin start = 1'b0; break; end
         end
      end
      start = 1'b0;
      checks++;
      assert (nd == 2) else begin errors++; $error("FAIL b2b_count: got %0d exp 2", nd); end
      repeat (4) @(negedge clk);
      checks++;
      assert (sb_q.size() == 0) else begin errors++; $error("FAIL b2b_drain: got %0d exp 0", sb_q.size()); end

      // reset in RUN aborts without a done pulse
      multiplier = 8'd5; multiplicand = 8'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      assert (dp_shift_en === 1'b1) else begin errors++; $error("FAIL rst_pre_run: got %0b exp 1", dp_shift_en); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      assert ({busy, done, err, dp_load, dp_shift_en, dp_reg_en, dp_psel} === 7'b0) else begin
         errors++; $error("FAIL rst_mid_run: got %b exp 0", {busy, done, err, dp_load, dp_shift_en, dp_reg_en, dp_psel});
      end
      checks++;
      assert (result === 16'h0) else begin errors++; $error("FAIL rst_result: got %h exp 0", result); end
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      assert (busy === 1'b0) else begin errors++; $error("FAIL rst_idle: got %0b exp 0", busy); end

      run_op(8'd9, 8'hF7, 16'hFFAF, 1'b0, 1'b1, 7, -10, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
